barycentric_interp: RTL and testbench

- Inverse of the barycentric solver: given weights (u, v, w) and three per-vertex attribute vectors A, B, C, produces P = u*A + v*B + w*C per component.
- Sits downstream of the barycentric solver in the rasterizer.
- Reconstructs interpolated position, depth, colour or UV for each accepted fragment.
- Attributes are loaded once per triangle via init; weights then stream in at one sample per cycle through a fixed-latency pipeline.

---
 rtl/bary_pkg.sv | 19 +
 rtl/bary_mac3.sv | 90 +++++++++
 rtl/barycentric_interp.sv | 142 ++++++++++++++
 tb/tb_barycentric_interp.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bary_pkg.sv
// Shared fixed-point constants and types for the barycentric solver/interpolator pair.
package bary_pkg;

  localparam int BARY_CW = 32;
  localparam int LATENCY = 3;
  localparam int FBITS   = BARY_CW / 2;
  localparam logic [BARY_CW-1:0] FP_ONE = BARY_CW'(1) << FBITS;
  localparam int FP_HIGH = BARY_CW * 3 / 2 - 1;
  localparam int FP_LOW  = FBITS;

  typedef logic signed [2:0][BARY_CW-1:0] vec3_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_t;

endpackage

// File: rtl/bary_mac3.sv
// One component of P = u*A + v*B + w*C: product stage (S2) and sum/slice stage (S3).
// With BARY_INTERP_SAT_EN defined the slice clamps to the signed word range
// and reports a saturation pulse; otherwise it wraps.
module bary_mac3
  import bary_pkg::*;
#(
  parameter int COORD_WIDTH = BARY_CW
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic signed [COORD_WIDTH-1:0] u_s1,
  input  logic signed [COORD_WIDTH-1:0] v_s1,
  input  logic signed [COORD_WIDTH-1:0] w_s1,
  input  logic signed [COORD_WIDTH-1:0] a_k,
  input  logic signed [COORD_WIDTH-1:0] b_k,
  input  logic signed [COORD_WIDTH-1:0] c_k,
  input  logic                          s3_en,
`ifdef BARY_INTERP_SAT_EN
  output logic                          sat,
`endif
  output logic        [COORD_WIDTH-1:0] p_k
);

  localparam int PW = 2 * COORD_WIDTH;
  localparam int SW = 2 * COORD_WIDTH + 2;
  localparam int HI = COORD_WIDTH * 3 / 2 - 1;
  localparam int LO = COORD_WIDTH / 2;

  logic signed [PW-1:0] prod_a, prod_b, prod_c;
  logic signed [SW-1:0] sum;
  logic [COORD_WIDTH-1:0] slice;
  logic [SW-1-HI:0] top_bits;
  logic unused_sum_bits;

  // S2: the three signed full-width products; operands sign-extended first.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      prod_a <= '0;
      prod_b <= '0;
      prod_c <= '0;
    end else begin
      prod_a <= PW'(u_s1) * PW'(a_k);
      prod_b <= PW'(v_s1) * PW'(b_k);
      prod_c <= PW'(w_s1) * PW'(c_k);
    end
  end

  // Sum with two guard bits, then take the integer-aligned window (plain truncation).
  always_comb begin
    sum      = SW'(prod_a) + SW'(prod_b) + SW'(prod_c);
    slice    = sum[HI:LO];
    top_bits = sum[SW-1:HI];
  end

  assign unused_sum_bits = ^{sum[LO-1:0], top_bits};

`ifdef BARY_INTERP_SAT_EN
  logic over, under;

  // In range only when every bit from the slice MSB upward matches the sign.
  always_comb begin
    over  = ~sum[SW-1] & (|top_bits);
    under = sum[SW-1] & ~(&top_bits);
    sat   = s3_en & (over | under);
  end

  // S3: register the clamped result; hold when no sample completes.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      p_k <= '0;
    end else if (s3_en) begin
      if (over)
        p_k <= {1'b0, {(COORD_WIDTH-1){1'b1}}};
      else if (under)
        p_k <= {1'b1, {(COORD_WIDTH-1){1'b0}}};
      else
        p_k <= slice;
    end
  end
`else
  // S3: register the wrapped slice; hold when no sample completes.
  always_ff @(posedge clk_in) begin
    if (rst_in)
      p_k <= '0;
    else if (s3_en)
      p_k <= slice;
  end
`endif

endmodule

// File: rtl/barycentric_interp.sv
// Barycentric attribute interpolator: P = u*A + v*B + w*C, three cycles latency.
// Holds the load FSM, the S1 weight register and the valid pipe; the math lives
// in three bary_mac3 instances. Optional macro: BARY_INTERP_SAT_EN (saturating
// output and sticky sat_flag).
//
// Handshake: valid_in has no ready. A sample is taken on a clock edge iff
// valid_in=1, the FSM is READY and init=0; anything else is dropped. valid_out
// is a one-cycle qualifier for p with no backpressure; p holds between results.
module barycentric_interp
  import bary_pkg::*;
#(
  parameter int COORD_WIDTH = BARY_CW
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                init,
  input  logic signed [2:0][COORD_WIDTH-1:0]  a,
  input  logic signed [2:0][COORD_WIDTH-1:0]  b,
  input  logic signed [2:0][COORD_WIDTH-1:0]  c,
  input  logic                                valid_in,
  input  logic signed [COORD_WIDTH-1:0]       u,
  input  logic signed [COORD_WIDTH-1:0]       v,
  input  logic signed [COORD_WIDTH-1:0]       w,
  output logic signed [2:0][COORD_WIDTH-1:0]  p,
  output logic                                valid_out,
  output logic                                init_done,
  output logic                                busy,
`ifdef BARY_INTERP_SAT_EN
  output logic                                sat_flag,
`endif
  output state_t                              state_dbg
);

  state_t state_q, state_d;

  logic signed [2:0][COORD_WIDTH-1:0] a_q, b_q, c_q;
  logic signed [COORD_WIDTH-1:0] u_s1, v_s1, w_s1;
  logic [1:0] vp;
  logic accept, s3_en;
  logic [COORD_WIDTH-1:0] p_arr [3];

  // Next-state: init always (re)loads; LOAD lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (init) state_d = LOAD;
      LOAD:    state_d = READY;
      READY:   if (init) state_d = LOAD;
      default: state_d = EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in)
      state_q <= EMPTY;
    else
      state_q <= state_d;
  end

  assign accept    = valid_in & (state_q == READY) & ~init;
  // An init edge discards whatever would land in S3, so no result mixes triangles.
  assign s3_en     = vp[1] & ~init;
  assign init_done = (state_q == READY);
  assign busy      = (|vp) | valid_out;
  assign state_dbg = state_q;

  // Attribute registers, captured on the init pulse itself.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
    end else if (init) begin
      a_q <= a;
      b_q <= b;
      c_q <= c;
    end
  end

  // S1: weight register, loaded only for accepted samples.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      u_s1 <= '0;
      v_s1 <= '0;
      w_s1 <= '0;
    end else if (accept) begin
      u_s1 <= u;
      v_s1 <= v;
      w_s1 <= w;
    end
  end

  // Valid pipe: vp[0] tracks S1, vp[1] tracks S2, valid_out tracks S3; init flushes it.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      vp        <= '0;
      valid_out <= 1'b0;
    end else if (init) begin
      vp        <= '0;
      valid_out <= 1'b0;
    end else begin
      vp        <= {vp[0], accept};
      valid_out <= vp[1];
    end
  end

`ifdef BARY_INTERP_SAT_EN
  logic [2:0] sat_k;

  // Sticky saturation flag, cleared by reset or a new triangle.
  always_ff @(posedge clk_in) begin
    if (rst_in)
      sat_flag <= 1'b0;
    else if (init)
      sat_flag <= 1'b0;
    else if (|sat_k)
      sat_flag <= 1'b1;
  end
`endif

  for (genvar k = 0; k < 3; k++) begin : g_mac
    bary_mac3 #(.COORD_WIDTH(COORD_WIDTH)) u_mac (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .u_s1   (u_s1),
      .v_s1   (v_s1),
      .w_s1   (w_s1),
      .a_k    (a_q[k]),
      .b_k    (b_q[k]),
      .c_k    (c_q[k]),
      .s3_en  (s3_en),
`ifdef BARY_INTERP_SAT_EN
      .sat    (sat_k[k]),
`endif
      .p_k    (p_arr[k])
    );
  end

  assign p = {p_arr[2], p_arr[1], p_arr[0]};

endmodule

// File: tb/tb_barycentric_interp.sv
// Directed bench for barycentric_interp; expected values are hand-computed Q16.16.
module tb_barycentric_interp;
  import bary_pkg::*;

  localparam int W = BARY_CW;

  logic clk_in = 1'b0;
  logic rst_in, init, valid_in;
  logic signed [2:0][W-1:0] a, b, c, p;
  logic signed [W-1:0] u, v, w;
  logic valid_out, init_done, busy;
  state_t state_dbg;
`ifdef BARY_INTERP_SAT_EN
  logic sat_flag;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [3*W-1:0] exp_q[$];
  logic [3*W-1:0] last_p;

  barycentric_interp dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .init      (init),
    .a         (a),
    .b         (b),
    .c         (c),
    .valid_in  (valid_in),
    .u         (u),
    .v         (v),
    .w         (w),
    .p         (p),
    .valid_out (valid_out),
    .init_done (init_done),
    .busy      (busy),
`ifdef BARY_INTERP_SAT_EN
    .sat_flag  (sat_flag),
`endif
    .state_dbg (state_dbg)
  );

  // Clock: 10 time-unit period.
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [3*W-1:0] obs, input logic [3*W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle so outputs are read away from the edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [3*W-1:0] vec(input logic [W-1:0] x0, input logic [W-1:0] x1,
                                         input logic [W-1:0] x2);
    return {x2, x1, x0};
  endfunction

  task automatic send(input logic [W-1:0] uu, input logic [W-1:0] vv, input logic [W-1:0] ww);
    valid_in = 1'b1;
    u = uu;
    v = vv;
    w = ww;
  endtask

  task automatic idle();
    valid_in = 1'b0;
  endtask

  // Pulse init with new attributes; init_done must rise two cycles after the pulse.
  task automatic load_tri(input logic [3*W-1:0] av, input logic [3*W-1:0] bv,
                          input logic [3*W-1:0] cv);
    a = av;
    b = bv;
    c = cv;
    init = 1'b1;
    tick();
    init = 1'b0;
    check("load_state", state_dbg, LOAD);
    check("load_init_done_low", init_done, 1'b0);
    tick();
    check("load_init_done_high", init_done, 1'b1);
  endtask

  initial begin
    rst_in = 1'b1; init = 1'b0; valid_in = 1'b0;
    a = '0; b = '0; c = '0; u = '0; v = '0; w = '0;
    tick();
    tick();
    check("rst_p", p, '0);
    check("rst_valid_out", valid_out, 1'b0);
    check("rst_init_done", init_done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", state_dbg, EMPTY);
    rst_in = 1'b0;

    // Pre-init gating: samples before any init are dropped.
    send(32'h10000, 32'h10000, 32'h10000);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("preinit_valid_out", valid_out, 1'b0);
      check("preinit_busy", busy, 1'b0);
    end
    idle();

    // Identity attributes: p equals the weights.
    load_tri(vec(32'h10000, 0, 0), vec(0, 32'h10000, 0), vec(0, 0, 32'h10000));
    send(32'h4000, 32'h8000, 32'h4000);
    tick();
    idle();
    check("id_busy", busy, 1'b1);
    check("id_valid_n1", valid_out, 1'b0);
    tick();
    check("id_valid_n2", valid_out, 1'b0);
    tick();
    check("id_valid_n3", valid_out, 1'b1);
    check("id_p", p, vec(32'h4000, 32'h8000, 32'h4000));
    tick();
    check("id_valid_n4", valid_out, 1'b0);
    check("id_p_hold", p, vec(32'h4000, 32'h8000, 32'h4000));

    // Streaming: 8 back-to-back samples, a = (2.0, 1.0, -1.0), b = c = 0.
    load_tri(vec(32'h20000, 32'h10000, 32'hFFFF0000), '0, '0);
    for (int t = 0; t < 12; t++) begin
      if (t < 8) begin
        send(32'(t * 32'h2000), $urandom, $urandom);
        exp_q.push_back(vec(32'(t * 32'h4000), 32'(t * 32'h2000), 32'(-(t * 32'h2000))));
      end else begin
        idle();
      end
      tick();
      check("stream_valid_out", valid_out, (t >= LATENCY - 1) && (t < 8 + LATENCY - 1));
      if (valid_out && exp_q.size() > 0)
        check("stream_p", p, exp_q.pop_front());
      if (t != 9)
        check("stream_busy", busy, t < 9);
    end
    check("stream_all_out", 96'(exp_q.size()), 96'(0));
    last_p = vec(32'h1C000, 32'hE000, 32'hFFFF2000);
    check("stream_p_hold", p, last_p);

    // Re-init flush: two samples in flight are discarded by init.
    send(32'h10000, 0, 0);
    tick();
    send(32'h10000, 0, 0);
    tick();
    a = vec(32'h30000, 0, 0);
    b = '0;
    c = '0;
    init = 1'b1;
    send(32'h10000, 0, 0);
    tick();
    init = 1'b0;
    check("flush_state_load", state_dbg, LOAD);
    check("flush_valid_n1", valid_out, 1'b0);
    check("flush_p_hold", p, last_p);
    send(32'h10000, 0, 0);
    tick();
    check("flush_valid_n2", valid_out, 1'b0);
    send(32'h8000, 0, 0);
    tick();
    check("flush_valid_n3", valid_out, 1'b0);
    idle();
    tick();
    check("flush_valid_n4", valid_out, 1'b0);
    tick();
    check("flush_new_valid", valid_out, 1'b1);
    check("flush_new_p", p, vec(32'h18000, 0, 0));
    tick();
    check("flush_done_valid", valid_out, 1'b0);
    check("flush_done_busy", busy, 1'b0);

    // Truncation toward -inf: -2^-16 * 0.5 floors to -2^-16.
    load_tri(vec(32'hFFFFFFFF, 0, 0), '0, '0);
    send(32'h8000, 0, 0);
    tick();
    idle();
    tick();
    tick();
    check("trunc_valid", valid_out, 1'b1);
    check("trunc_p", p, vec(32'hFFFFFFFF, 0, 0));
`ifdef BARY_INTERP_SAT_EN
    check("trunc_sat_flag", sat_flag, 1'b0);
`endif

    // Positive overflow: 32767 + 32767.
    load_tri(vec(32'h7FFF0000, 0, 0), vec(32'h7FFF0000, 0, 0), '0);
    send(32'h10000, 32'h10000, 0);
    tick();
    idle();
    tick();
    tick();
    check("ovf_pos_valid", valid_out, 1'b1);
`ifdef BARY_INTERP_SAT_EN
    check("ovf_pos_p", p, vec(32'h7FFFFFFF, 0, 0));
    check("ovf_pos_sat_flag", sat_flag, 1'b1);
`else
    check("ovf_pos_p", p, vec(32'hFFFE0000, 0, 0));
`endif

    // Negative overflow: -32768 + -32768.
    load_tri(vec(32'h80000000, 0, 0), vec(32'h80000000, 0, 0), '0);
`ifdef BARY_INTERP_SAT_EN
    check("ovf_neg_sat_cleared", sat_flag, 1'b0);
`endif
    send(32'h10000, 32'h10000, 0);
    tick();
    idle();
    tick();
    tick();
    check("ovf_neg_valid", valid_out, 1'b1);
`ifdef BARY_INTERP_SAT_EN
    check("ovf_neg_p", p, vec(32'h80000000, 0, 0));
    check("ovf_neg_sat_flag", sat_flag, 1'b1);
`else
    check("ovf_neg_p", p, vec(32'h00000000, 0, 0));
`endif

    // Reset mid-stream with samples in flight.
    load_tri(vec(32'h10000, 32'h20000, 32'h30000), '0, '0);
    send(32'h10000, 0, 0);
    tick();
    tick();
    tick();
    check("midrst_pre_valid", valid_out, 1'b1);
    check("midrst_pre_p", p, vec(32'h10000, 32'h20000, 32'h30000));
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    check("midrst_valid_out", valid_out, 1'b0);
    check("midrst_init_done", init_done, 1'b0);
    check("midrst_p", p, '0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_state", state_dbg, EMPTY);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("midrst_gated_valid", valid_out, 1'b0);
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
